// File: rtl/apb_master_bridge.sv
// Bridges a single-outstanding req/gnt/rvalid port onto an APB3 initiator (SETUP then ACCESS).
// Optional ACCESS-phase timeout is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_next;
    logic   done;
    logic   timeout;
    logic   timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Fires on the ACCESS cycle whose stall would make the count reach the limit.
    assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready_i) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        gnt_o      = 1'b0;
        psel_o     = 1'b0;
        penable_o  = 1'b0;
        rvalid_o   = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                gnt_o = req_i & ~rst_i;
                if (req_i) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel_o     = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                // Slave completion wins over a timeout landing on the same cycle.
                if (pready_i) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rvalid_o   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are held in the APB output registers for the whole transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
        end else if (gnt_o) begin
            paddr_o  <= addr_i;
            pwdata_o <= wdata_i;
            pwrite_o <= we_i;
        end
    end

    // Response registers hold until the next completion; writes return zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else if (done) begin
            rdata_o <= pwrite_o ? '0 : prdata_i;
            err_o   <= pslverr_i;
        end else if (timeout) begin
            rdata_o <= '0;
            err_o   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed plan cases plus randomized transactions
// against a cycle-count/expected-response model; the bench acts as the APB slave.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_gnt = 0;
    int exp_gap = -1;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pwrite_o (pwrite),
        .psel_o   (psel),
        .penable_o(penable),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transfer. nwait = wait states the slave inserts before pready.
    // hold = keep req high afterwards so the next call checks back-to-back grant spacing.
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input int nwait, input logic slv, input logic hold);
        logic [DW-1:0] rd;
        logic          timed_out;
        int            n_acc;
        int            t0;
        rd        = $urandom;
        timed_out = 1'b0;
        n_acc     = nwait + 1;
`ifdef APB_MASTER_TIMEOUT_EN
        if (nwait >= TO) begin
            timed_out = 1'b1;
            n_acc     = TO;
        end
`endif
        req   = 1'b1;
        addr  = a;
        we    = w;
        wdata = d;
        @(negedge clk);
        check("idle_gnt", gnt, 1);
        check("idle_psel", psel, 0);
        if (exp_gap >= 0) check("gnt_gap", cyc - last_gnt, exp_gap);
        t0       = cyc;
        last_gnt = cyc;
        exp_gap  = hold ? 3 + n_acc : -1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        we    = ~w;
        @(negedge clk);
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_gnt", gnt, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwdata", pwdata, d);
        check("setup_pwrite", pwrite, w);
        @(posedge clk); #1;
        for (int i = 0; i < n_acc; i++) begin
            pready  = (i == nwait);
            pslverr = (i == nwait) ? slv : 1'b1;
            prdata  = (i == nwait) ? rd : DW'($urandom);
            @(negedge clk);
            check("access_psel", psel, 1);
            check("access_penable", penable, 1);
            check("access_gnt", gnt, 0);
            check("access_rvalid", rvalid, 0);
            check("access_paddr", paddr, a);
            check("access_pwdata", pwdata, d);
            @(posedge clk); #1;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        @(negedge clk);
        check("resp_rvalid", rvalid, 1);
        check("resp_latency", cyc - t0, 2 + n_acc);
        check("resp_psel", psel, 0);
        check("resp_penable", penable, 0);
        check("resp_gnt", gnt, 0);
        check("resp_err", err, timed_out ? 1'b1 : slv);
        check("resp_rdata", rdata, (timed_out || w) ? '0 : rd);
        @(posedge clk); #1;
        if (!hold) begin
            @(negedge clk);
            check("post_rvalid", rvalid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed plan cases
        txn(32'h1A10_0000, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        txn(32'h1A10_1004, 1'b0, 32'h0, 3, 1'b0, 1'b0);
        txn(32'h1A10_2008, 1'b0, 32'h0, 0, 1'b1, 1'b0);
        txn(32'h1A10_200C, 1'b0, 32'h0, 2, 1'b0, 1'b0);
        txn(32'h0000_0003, 1'b1, 32'h5555_AAAA, 1, 1'b0, 1'b1);
        txn(32'hFFFF_FFFF, 1'b0, 32'h0, 0, 1'b0, 1'b1);
        txn(32'h1A10_3000, 1'b1, 32'h1111_2222, 2, 1'b1, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        txn(32'h1A10_4000, 1'b0, 32'h0, 10, 1'b0, 1'b0);
        txn(32'h1A10_4004, 1'b0, 32'h0, TO - 1, 1'b1, 1'b0);
        txn(32'h1A10_4008, 1'b0, 32'h0, TO - 1, 1'b0, 1'b0);
`else
        txn(32'h1A10_4000, 1'b0, 32'h0, 10, 1'b0, 1'b0);
`endif

        // Reset while the slave is stalling in ACCESS
        req   = 1'b1;
        addr  = 32'h1A10_5000;
        we    = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_penable_before", penable, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_paddr", paddr, 0);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_gap = -1;
        @(negedge clk);
        check("rst_after_rvalid", rvalid, 0);
        check("rst_after_psel", psel, 0);
        @(posedge clk); #1;
        txn(32'h1A10_6000, 1'b0, 32'h0, 1, 1'b0, 1'b0);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            txn(AW'($urandom), 1'($urandom), DW'($urandom), int'($urandom_range(0, 6)),
                1'($urandom), (k < 39) ? 1'($urandom) : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
